cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_if.sv | 35 +++
 rtl/cache_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cache_ctrl_if.sv
// CPU/memory bus bundle for cache_ctrl: read request/response channel,
// memory beat channel, flush pulse and statistics counters.
interface cache_ctrl_if #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 10
);
  localparam int ADDR_W = TAG_W + INDEX_W + 2;

  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              cpu_hit;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_data;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  // slave: the cache controller; master: the CPU/memory side driving it
  modport slave (
    input  cpu_valid, cpu_addr, flush, mem_ack, mem_data,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit,
           mem_req, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_valid, cpu_addr, flush, mem_ack, mem_data,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit,
           mem_req, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller, 4-word lines, 4-beat line fill.
// Optional macro STATS_EN builds saturating hit/miss counters.
module cache_ctrl #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  cache_ctrl_if.slave   bus
);
  localparam int ADDR_W = TAG_W + INDEX_W + 2;
  localparam int LINES  = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr_q;
  logic [1:0]           beat;
  logic [INDEX_W-1:0]   flush_idx;
  logic [31:0]          rdata_q;
  logic                 hit_q;
  logic [LINES-1:0]     valid;
  logic [3:0][31:0]     fill_buf;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [3:0][31:0]     data_mem [LINES];

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [1:0]           req_off;
  logic                 lookup_hit;

  assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx    = addr_q[INDEX_W+1:2];
  assign req_off    = addr_q[1:0];
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.flush)          state_nxt = FLUSH;
        else if (bus.cpu_valid) state_nxt = LOOKUP;
      end
      LOOKUP: state_nxt = lookup_hit ? RESP : FILL;
      FILL:   if (bus.mem_ack && beat == 2'd3) state_nxt = WRITE;
      WRITE:  state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      FLUSH:  if (&flush_idx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control/status registers; valid bits are the only array state that resets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      beat      <= '0;
      flush_idx <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.flush && bus.cpu_valid) addr_q <= bus.cpu_addr;
          beat      <= '0;
          flush_idx <= '0;
        end
        LOOKUP: begin
          hit_q <= lookup_hit;
          beat  <= '0;
          if (lookup_hit) rdata_q <= data_mem[req_idx][req_off];
        end
        FILL: if (bus.mem_ack) beat <= beat + 2'd1;
        WRITE: begin
          valid[req_idx] <= 1'b1;
          rdata_q        <= fill_buf[req_off];
        end
        FLUSH: begin
          valid[flush_idx] <= 1'b0;
          flush_idx        <= flush_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage only commits in WRITE, so an aborted fill never lands in the arrays.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.mem_ack) fill_buf[beat] <= bus.mem_data;
    if (state == WRITE) begin
      data_mem[req_idx] <= fill_buf;
      tag_mem[req_idx]  <= req_tag;
    end
  end

  assign bus.cpu_ready  = (state == IDLE);
  assign bus.cpu_rvalid = (state == RESP);
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_hit    = hit_q;
  assign bus.mem_req    = (state == FILL);
  assign bus.mem_addr   = {addr_q[ADDR_W-1:2], beat};

`ifdef STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule
